// File: rtl/rst_seq.sv
// Reset synchroniser and sequencer: synchronises an asynchronous active-low
// reset, stretches it by a hold time, then releases N_OUT resets in index
// order with a fixed gap. A level-sampled software request restarts the sequence.
module rst_seq #(
  parameter int               SYNC_STAGES = 2,
  parameter int               N_OUT       = 3,
  parameter int               HOLD_CYCLES = 16,
  parameter int               GAP_CYCLES  = 8,
  parameter logic [N_OUT-1:0] ACTIVE_HIGH = '0
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             sw_rst_req,
  output logic [N_OUT-1:0] rst_out,
  output logic             rst_done,
  output logic             busy
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_OUT - 1);
  localparam logic [IW-1:0] IDX_FIRST = IW'(1);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_RELEASE,
    ST_RUN
  } state_t;

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   sync_n;

  state_t           state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [N_OUT-1:0] rel_q, rel_d;
  logic [N_OUT-1:0] out_q, out_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  assign sync_n = sync_p0[SYNC_STAGES-1];

  // Synchroniser: asserts asynchronously, releases after SYNC_STAGES edges.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Sequencer next-state and registered-output values.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    rel_d   = rel_q;
    done_d  = done_q;
    busy_d  = busy_q;
    case (state_q)
      ST_ASSERT: begin
        rel_d  = '0;
        done_d = 1'b0;
        busy_d = 1'b1;
        if (sw_rst_req || !sync_n) begin
          // hold time restarts from the last cycle the request was high
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          hold_d   = '0;
          rel_d[0] = 1'b1;
          idx_d    = IDX_FIRST;
          gap_d    = '0;
          if (N_OUT == 1) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_RELEASE: begin
        if (sw_rst_req) begin
          state_d = ST_ASSERT;
          rel_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          hold_d  = '0;
        end else if (gap_q == GAP_LAST) begin
          rel_d[idx_q] = 1'b1;
          gap_d        = '0;
          idx_d        = idx_q + IW'(1);
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      ST_RUN: begin
        if (sw_rst_req) begin
          state_d = ST_ASSERT;
          rel_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = ST_ASSERT;
        rel_d   = '0;
        done_d  = 1'b0;
        busy_d  = 1'b1;
        hold_d  = '0;
      end
    endcase
    out_d = rel_d ^ ACTIVE_HIGH;
  end

  // Sequencer registers; rst_in forces every output asserted without a clock.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_ASSERT;
      hold_q  <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      rel_q   <= '0;
      out_q   <= ACTIVE_HIGH;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      rel_q   <= rel_d;
      out_q   <= out_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign rst_out  = out_q;
  assign rst_done = done_q;
  assign busy     = busy_q;

endmodule
